// File: rtl/debounce_bank.sv
// rtl/debounce_bank.sv - multi-channel input debouncer with edge pulses and sticky event flags
//
// Purpose:
//   Each channel synchronizes a raw asynchronous input through two flops.
//   The channel then requires a mismatch between the synchronized value and
//   the current output that stays stable for UPPER_BOUND enabled ticks
//   before the output follows it.
//   Debounced edges produce one-cycle rise/fall pulses. Those pulses also
//   set sticky pending flags, which remain set until a consumer acknowledges
//   them.
//
// Ports:
//   clk          - sole clock, rising edge
//   rst          - synchronous active-high reset
//   clock_enable - debounce sample tick shared by all channels
//   in_signal    - raw asynchronous inputs, one bit per channel
//   out_signal   - debounced registered levels
//   rise / fall  - one-cycle pulses on debounced 0->1 / 1->0
//   event_valid  - high while any pending flag is set
//   event_rise   - sticky pending rise flags
//   event_fall   - sticky pending fall flags
//   event_ack    - clears pending flags (ignored when nothing is pending)

module debounce_bank #(
  parameter int                    CHANNELS    = 4,
  parameter int                    UPPER_BOUND = 16,
  parameter logic [CHANNELS-1:0]   INIT_LEVEL  = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clock_enable,
  input  logic [CHANNELS-1:0] in_signal,
  output logic [CHANNELS-1:0] out_signal,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic                event_valid,
  output logic [CHANNELS-1:0] event_rise,
  output logic [CHANNELS-1:0] event_fall,
  input  logic                event_ack
);

  localparam int            CW   = $clog2(UPPER_BOUND) + 1;
  localparam logic [CW-1:0] LAST = CW'(UPPER_BOUND - 1);

  logic [CHANNELS-1:0] sync_1;
  logic [CHANNELS-1:0] synch;
  logic [CW-1:0]       count [CHANNELS];
  logic                ack_take;

  // Pending flags come straight from registers, so event_ack never reaches
  // event_valid combinationally.
  assign event_valid = |{event_rise, event_fall};
  assign ack_take    = event_ack & event_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1     <= INIT_LEVEL;
      synch      <= INIT_LEVEL;
      out_signal <= INIT_LEVEL;
      rise       <= '0;
      fall       <= '0;
      event_rise <= '0;
      event_fall <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        count[i] <= '0;
      end
    end else begin
      sync_1 <= in_signal;
      synch  <= sync_1;

      for (int i = 0; i < CHANNELS; i++) begin
        rise[i] <= 1'b0;
        fall[i] <= 1'b0;
        if (synch[i] == out_signal[i]) begin
          // Any agreement discards progress, so a bounce restarts the count.
          count[i] <= '0;
        end else if (clock_enable) begin
          if (count[i] == LAST) begin
            out_signal[i] <= synch[i];
            count[i]      <= '0;
            rise[i]       <= synch[i];
            fall[i]       <= ~synch[i];
          end else begin
            count[i] <= count[i] + 1'b1;
          end
        end
      end

      // A pulse in the acknowledge cycle survives the clear.
      event_rise <= (ack_take ? '0 : event_rise) | rise;
      event_fall <= (ack_take ? '0 : event_fall) | fall;
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
// tb/tb_debounce_bank.sv - scoreboard bench for debounce_bank (UPPER_BOUND=4 and UPPER_BOUND=1 builds)

module tb_debounce_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       ce;
  logic       ack;
  logic [3:0] in_sig;
  logic [3:0] out_sig, rise, fall, ev_rise, ev_fall;
  logic       ev_valid;

  logic       in1;
  logic [0:0] out1, rise1, fall1, ev_rise1, ev_fall1;
  logic       ev_valid1;

  always #5 clk = ~clk;

  debounce_bank #(.CHANNELS(4), .UPPER_BOUND(4), .INIT_LEVEL(4'b0000)) dut (
    .clk(clk), .rst(rst), .clock_enable(ce), .in_signal(in_sig),
    .out_signal(out_sig), .rise(rise), .fall(fall), .event_valid(ev_valid),
    .event_rise(ev_rise), .event_fall(ev_fall), .event_ack(ack)
  );

  debounce_bank #(.CHANNELS(1), .UPPER_BOUND(1), .INIT_LEVEL(1'b0)) dut_ub1 (
    .clk(clk), .rst(rst), .clock_enable(1'b1), .in_signal(in1),
    .out_signal(out1), .rise(rise1), .fall(fall1), .event_valid(ev_valid1),
    .event_rise(ev_rise1), .event_fall(ev_fall1), .event_ack(1'b0)
  );

  typedef struct packed {
    logic [3:0] o, r, f, er, ef;
    logic       v;
    logic       o1, r1, f1;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  logic [3:0] e_out = '0, e_rise = '0, e_fall = '0, e_er = '0, e_ef = '0;
  logic       e_out1 = 1'b0, e_rise1 = 1'b0, e_fall1 = 1'b0;

  task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue what the DUTs must show after the edge.
  task automatic tick(input logic [3:0] in_v, input logic ce_v, input logic ack_v, input logic rst_v);
    exp_t e;
    in_sig = in_v;
    ce     = ce_v;
    ack    = ack_v;
    rst    = rst_v;
    e.o  = e_out;  e.r  = e_rise; e.f = e_fall; e.er = e_er; e.ef = e_ef;
    e.v  = |{e_er, e_ef};
    e.o1 = e_out1; e.r1 = e_rise1; e.f1 = e_fall1;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq("out_signal", out_sig, e.o);
      check_eq("rise", rise, e.r);
      check_eq("fall", fall, e.f);
      check_eq("event_rise", ev_rise, e.er);
      check_eq("event_fall", ev_fall, e.ef);
      check_eq("event_valid", {3'b000, ev_valid}, {3'b000, e.v});
      check_eq("ub1_out", {3'b000, out1}, {3'b000, e.o1});
      check_eq("ub1_rise", {3'b000, rise1}, {3'b000, e.r1});
      check_eq("ub1_fall", {3'b000, fall1}, {3'b000, e.f1});
    end
  end

  initial begin
    in1 = 1'b0;
    // Reset state
    tick(4'b0000, 1, 1, 1);
    tick(4'b0000, 1, 0, 1);
    tick(4'b0000, 1, 0, 0);
    tick(4'b0000, 1, 0, 0);

    // ch0 0->1 held: out changes on the 6th edge
    for (int k = 0; k < 5; k++) tick(4'b0001, 1, 0, 0);
    e_out = 4'b0001; e_rise = 4'b0001;
    tick(4'b0001, 1, 0, 0);
    e_rise = 4'b0000; e_er = 4'b0001;
    tick(4'b0001, 1, 0, 0);
    e_er = 4'b0000;
    tick(4'b0001, 1, 1, 0);
    tick(4'b0001, 1, 1, 0);          // ack with nothing pending
    tick(4'b0001, 1, 0, 0);

    // ch1 three-cycle glitch is swallowed
    repeat (3) tick(4'b0011, 1, 0, 0);
    repeat (6) tick(4'b0001, 1, 0, 0);

    // clock_enable one cycle in four, ch2 held high
    for (int k = 0; k < 16; k++) begin
      if (k == 15) begin
        e_out = 4'b0101; e_rise = 4'b0100;
      end
      tick(4'b0101, (k % 4) == 3, 0, 0);
    end
    e_rise = 4'b0000; e_er = 4'b0100;
    tick(4'b0101, 0, 0, 0);
    e_er = 4'b0000;
    tick(4'b0101, 1, 1, 0);

    // ch1/ch3 rise pending, ack lands in the cycle of the ch2 fall pulse
    for (int k = 0; k < 8; k++) begin
      if (k == 5) begin
        e_out = 4'b1111; e_rise = 4'b1010;
      end else if (k == 6) begin
        e_out = 4'b1011; e_rise = 4'b0000; e_fall = 4'b0100; e_er = 4'b1010;
      end else if (k == 7) begin
        e_fall = 4'b0000; e_er = 4'b0000; e_ef = 4'b0100;
      end
      tick((k == 0) ? 4'b1111 : 4'b1011, 1, k == 7, 0);
    end
    e_ef = 4'b0000;
    tick(4'b1011, 1, 1, 0);

    // Reset mid-count discards progress
    e_out = 4'b0000;
    tick(4'b0000, 1, 0, 1);
    tick(4'b0000, 1, 0, 0);
    tick(4'b0000, 1, 0, 0);
    for (int k = 0; k < 4; k++) tick(4'b0001, 1, 0, 0);
    tick(4'b0001, 1, 1, 1);
    for (int k = 0; k < 6; k++) begin
      if (k == 5) begin
        e_out = 4'b0001; e_rise = 4'b0001;
      end
      tick(4'b0001, 1, 0, 0);
    end
    e_rise = 4'b0000; e_er = 4'b0001;
    tick(4'b0001, 1, 0, 0);

    // UPPER_BOUND=1 build: output follows 3 edges after input change
    in1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        e_out1 = 1'b1; e_rise1 = 1'b1;
      end else if (k == 3) begin
        e_rise1 = 1'b0;
      end
      tick(4'b0001, 1, 0, 0);
    end
    in1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        e_out1 = 1'b0; e_fall1 = 1'b1;
      end else if (k == 3) begin
        e_fall1 = 1'b0;
      end
      tick(4'b0001, 1, 0, 0);
    end

    @(negedge clk);
    #1;
    check_eq("scoreboard_drained", 4'(sb.size()), 4'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
